// File: rtl/tdm_demux_if.sv
// tdm_demux_if: serial TDM line in, one parallel frame of channel values out.
interface tdm_demux_if #(
    parameter int N_CH = 4,
    parameter int W    = 1,
    parameter int CW   = 2
);
    logic [W-1:0]      din;
    logic              din_vld;
    logic              sync;
    logic [N_CH*W-1:0] dout;
    logic              frame_vld;
    logic [CW-1:0]     ch_sel;
    logic              locked;
    logic              err;
    modport master(output din, din_vld, sync, input dout, frame_vld, ch_sel, locked, err);
    modport slave(input din, din_vld, sync, output dout, frame_vld, ch_sel, locked, err);
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: aligns on the slot-0 sync flag, collects one frame of slots, publishes it whole.
module tdm_demux #(
    parameter int N_CH = 4,
    parameter int W    = 1,
    parameter int CW   = 2
) (
    input logic        c,
    input logic        rst_n,
    tdm_demux_if.slave t
);
    typedef enum logic {HUNT, LOCK} state_t;
    state_t                  state, state_nx;
    logic [CW-1:0]           ch_sel, ch_nx;
    logic [(N_CH-1)*W-1:0]   shadow, shadow_nx;
    logic [N_CH*W-1:0]       dout, dout_nx;
    logic                    fv_nx, err_nx;
    logic                    frame_vld, locked, err;
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            ch_sel    <= '0;
            shadow    <= '0;
            dout      <= '0;
            frame_vld <= 1'b0;
            err       <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nx;
            ch_sel    <= ch_nx;
            shadow    <= shadow_nx;
            dout      <= dout_nx;
            frame_vld <= fv_nx;
            err       <= err_nx;
            locked    <= (state_nx == LOCK);
        end
    end
    always_comb begin
        state_nx  = state;
        ch_nx     = ch_sel;
        shadow_nx = shadow;
        dout_nx   = dout;
        fv_nx     = 1'b0;
        err_nx    = 1'b0;
        if (t.din_vld) begin
            if (t.sync) begin
                // any sync restarts the frame; off slot 0 it also flags a short frame
                if (state == LOCK && ch_sel != '0) err_nx = 1'b1;
                shadow_nx[W-1:0] = t.din;
                ch_nx            = CW'(1);
                state_nx         = LOCK;
            end else if (state == LOCK) begin
                if (ch_sel == '0) begin
                    err_nx   = 1'b1;
                    state_nx = HUNT;
                end else if (ch_sel == CW'(N_CH-1)) begin
                    dout_nx = {t.din, shadow};
                    fv_nx   = 1'b1;
                    ch_nx   = '0;
                end else begin
                    for (int k = 1; k < N_CH-1; k++)
                        if (ch_sel == CW'(k)) shadow_nx[k*W +: W] = t.din;
                    ch_nx = ch_sel + CW'(1);
                end
            end
        end
    end
    assign t.dout      = dout;
    assign t.frame_vld = frame_vld;
    assign t.ch_sel    = ch_sel;
    assign t.locked    = locked;
    assign t.err       = err;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed vector table plus an async-reset sequence for tdm_demux (N_CH=4, W=1).
module tb_tdm_demux;
    typedef struct {
        logic       vld, sync, din;
        logic [3:0] dout;
        logic       fv;
        logic [1:0] ch;
        logic       lk, er;
    } vec_t;
    logic c = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];
    tdm_demux_if #(.N_CH(4), .W(1), .CW(2)) t();
    tdm_demux #(.N_CH(4), .W(1), .CW(2)) dut(.c(c), .rst_n(rst_n), .t(t.slave));
    always #5 c = ~c;
    task automatic add(input logic vld, sync, din, input logic [3:0] dout, input logic fv,
                       input logic [1:0] ch, input logic lk, er);
        vec_t v;
        v.vld = vld; v.sync = sync; v.din = din; v.dout = dout;
        v.fv = fv; v.ch = ch; v.lk = lk; v.er = er;
        tbl.push_back(v);
    endtask
    // idle cycles carry sync=1/din=1 so an ignored-beat bug shows up
    task automatic gap(input int n, input logic [3:0] dout, input logic [1:0] ch, input logic lk);
        for (int i = 0; i < n; i++) add(1'b0, 1'b1, 1'b1, dout, 1'b0, ch, lk, 1'b0);
    endtask
    task automatic chk(input string nm, input logic [8:0] want);
        logic [8:0] got;
        got = {t.dout, t.frame_vld, t.ch_sel, t.locked, t.err};
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got dout=%b fv=%b ch=%0d lk=%b err=%b, want dout=%b fv=%b ch=%0d lk=%b err=%b",
                     nm, got[8:5], got[4], got[3:2], got[1], got[0],
                     want[8:5], want[4], want[3:2], want[1], want[0]);
        end
    endtask
    task automatic beat(input logic vld, sync, din);
        @(negedge c);
        t.din_vld = vld; t.sync = sync; t.din = din;
        @(posedge c);
        #1;
    endtask
    initial begin
        t.din_vld = 1'b0; t.sync = 1'b0; t.din = 1'b0;
        // basic frame
        add(1,1,1,4'b0000,0,1,1,0);
        add(1,0,0,4'b0000,0,2,1,0);
        add(1,0,1,4'b0000,0,3,1,0);
        add(1,0,1,4'b1101,1,0,1,0);
        gap(1, 4'b1101, 0, 1);
        // same frame with 3-cycle gaps
        add(1,1,1,4'b1101,0,1,1,0);  gap(3, 4'b1101, 1, 1);
        add(1,0,0,4'b1101,0,2,1,0);  gap(3, 4'b1101, 2, 1);
        add(1,0,1,4'b1101,0,3,1,0);  gap(3, 4'b1101, 3, 1);
        add(1,0,1,4'b1101,1,0,1,0);  gap(1, 4'b1101, 0, 1);
        // early sync at slot 2
        add(1,1,0,4'b1101,0,1,1,0);
        add(1,0,1,4'b1101,0,2,1,0);
        add(1,1,1,4'b1101,0,1,1,1);
        add(1,0,0,4'b1101,0,2,1,0);
        add(1,0,1,4'b1101,0,3,1,0);
        add(1,0,0,4'b0101,1,0,1,0);
        // lost alignment at slot 0, then relock
        add(1,0,1,4'b0101,0,0,0,1);
        add(1,1,1,4'b0101,0,1,1,0);
        add(1,0,1,4'b0101,0,2,1,0);
        add(1,0,1,4'b0101,0,3,1,0);
        add(1,0,1,4'b1111,1,0,1,0);
        // drop to HUNT, beats before sync are discarded
        add(1,0,0,4'b1111,0,0,0,1);
        for (int i = 0; i < 5; i++) add(1,0,1,4'b1111,0,0,0,0);
        add(1,1,0,4'b1111,0,1,1,0);
        add(1,0,0,4'b1111,0,2,1,0);
        add(1,0,0,4'b1111,0,3,1,0);
        add(1,0,1,4'b1000,1,0,1,0);
        // back-to-back frames: pulses 4 cycles apart
        add(1,1,1,4'b1000,0,1,1,0);
        add(1,0,0,4'b1000,0,2,1,0);
        add(1,0,1,4'b1000,0,3,1,0);
        add(1,0,0,4'b0101,1,0,1,0);
        add(1,1,0,4'b0101,0,1,1,0);
        add(1,0,1,4'b0101,0,2,1,0);
        add(1,0,1,4'b0101,0,3,1,0);
        add(1,0,1,4'b1110,1,0,1,0);
        gap(1, 4'b1110, 0, 1);
        #1 chk("reset", 9'b0);
        #11 rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            beat(tbl[i].vld, tbl[i].sync, tbl[i].din);
            chk($sformatf("vec%0d", i),
                {tbl[i].dout, tbl[i].fv, tbl[i].ch, tbl[i].lk, tbl[i].er});
        end
        // async reset mid-frame, then beats without sync must not produce a frame
        beat(1, 1, 1);
        chk("pre_rst_a", {4'b1110, 1'b0, 2'd1, 1'b1, 1'b0});
        beat(1, 0, 1);
        chk("pre_rst_b", {4'b1110, 1'b0, 2'd2, 1'b1, 1'b0});
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 9'b0);
        #1 rst_n = 1'b1;
        beat(1, 0, 1);
        chk("post_rst_a", 9'b0);
        beat(1, 0, 1);
        chk("post_rst_b", 9'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive end of the team's time-division multiplexed link.
- The transmit side rotates N_CH channel samples onto one shared data line and marks slot 0 with a sync flag.
- This block finds frame alignment, steers each slot's sample to its own channel register, and presents one complete frame of channel values in parallel with a one-cycle strobe.
- Sits between the serial TDM line and the per-channel consumers.

Parameters:
- N_CH, 4, number of channels (slots) per frame, 2..16.
- W, 1, data width of each slot sample, in bits.
- CW, 2, width of the slot counter; must satisfy 2**CW >= N_CH.

Ports:
- c  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  W  slot sample from the TDM line.
- din_vld  input  1  din carries a valid slot this cycle; cycles with din_vld=0 are ignored entirely.
- sync  input  1  frame marker; qualified only when din_vld=1; when asserted, the current beat is slot 0.
- dout  output  N_CH*W  last complete frame; channel k is at dout[k*W +: W].
- frame_vld  output  1  one-cycle pulse; dout has just been updated with a new frame.
- ch_sel  output  CW  slot index expected for the next valid beat.
- locked  output  1  high while in the LOCK state.
- err  output  1  one-cycle pulse on an alignment error.

Behaviour:
- Reset (rst_n=0, immediate, regardless of clock):
  - state=HUNT; ch_sel=0; dout=0; frame_vld=0; err=0; locked=0.
  - Shadow registers are cleared to 0.
- Two states: HUNT and LOCK. locked = (state==LOCK), registered.
- Beat definition: a rising edge with din_vld=1. Without din_vld, no state, counter or data changes, and frame_vld and err return to 0.
- HUNT:
  - Beats with sync=0 are discarded; ch_sel stays 0.
  - On a beat with sync=1: shadow[0]<=din, ch_sel<=1, state<=LOCK.
  - Special case N_CH==1 is not supported.
- LOCK, beat at slot s=ch_sel:
  - s==0 and sync=1: normal frame start. shadow[0]<=din, ch_sel<=1.
  - s==0 and sync=0: lost alignment. err pulse, beat discarded, state<=HUNT, ch_sel<=0. dout is held.
  - 0<s<N_CH-1 and sync=0: shadow[s]<=din, ch_sel<=s+1.
  - s==N_CH-1 and sync=0: dout<={din, shadow[N_CH-2..0]}, frame_vld<=1, ch_sel<=0.
  - s!=0 and sync=1: early sync (short frame).
    - err pulse; the partial frame is discarded and dout is held.
    - The beat is taken as a new slot 0: shadow[0]<=din, ch_sel<=1. State stays LOCK.
- Latency:
  - dout and frame_vld change on the same edge that samples the last slot (slot N_CH-1).
  - Both are visible in the following cycle.
  - frame_vld is exactly one cycle wide even with back-to-back frames.
- dout is held between frames and is never partially updated.
- frame_vld and err are never asserted in the same cycle.
- ch_sel wraps N_CH-1 -> 0 only through the last-slot rule above. Values >= N_CH are unreachable.
- If reset asserts mid-frame, partial data is lost and the block returns to HUNT. The first frame after reset requires a sync beat.

Test Plan:
- Reset, then N_CH=4, W=1: beats (sync,din) = (1,1),(0,0),(0,1),(0,1), all with din_vld=1 -> locked=1 after the 1st beat; after the 4th beat dout=4'b1101 and frame_vld=1 for exactly one cycle.
- Same frame with din_vld=0 gaps of 3 cycles between beats -> identical dout=4'b1101; ch_sel holds during the gaps; one frame_vld pulse.
- Beats before any sync, (0,1)x5, then (1,0),(0,0),(0,0),(0,1) -> no frame_vld during the first 5 beats; then dout=4'b1000, frame_vld=1.
- Locked with dout=4'b1101, then a sync at slot 2: beats (1,0),(0,1),(1,1),(0,0),(0,1),(0,0) -> err pulse at the 3rd beat; dout stays 4'b1101; after the 6th beat dout=4'b0101.
- Locked, then the slot-0 beat has sync=0 -> err=1, locked=0, ch_sel=0; next beats (1,1),(0,1),(0,1),(0,1) -> relock and dout=4'b1111.
- rst_n pulsed low between edges after 2 beats of a frame -> outputs go to 0 immediately, without waiting for a clock edge; the subsequent 2 beats without sync produce no frame_vld.
- Two back-to-back frames without gaps -> two frame_vld pulses exactly 4 cycles apart.
